vga_timing_gen: RTL

- Free-running VGA raster timing generator.
- Produces the pixel counters (hcount/vcount), sync and blanking signals that feed the background-drawing stage at the head of the video pipeline.
- Outputs are registered and mutually consistent: all signals in a given cycle describe the same pixel position.
- A pixel-enable input allows operation from a faster system clock; a frame-start pulse marks pixel (0,0).

---
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the raster-timing signals that run between the VGA timing
//   generator and the drawing stages behind it.
//
//   pix_en      pixel advance enable (driven by the consumer/system side)
//   hcount      horizontal pixel index
//   vcount      vertical line index
//   hsync       horizontal sync, active-high
//   hblnk       horizontal blanking
//   vsync       vertical sync, active-high
//   vblnk       vertical blanking
//   frame_start one-cycle pulse when the raster moves to pixel (0,0)
//
//   master: the timing generator (drives the counters and flags)
//   slave : a consumer of the raster timing (drives pix_en)
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pix_en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic             frame_start;

    modport master (
        input  pix_en,
        output hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start
    );

    modport slave (
        output pix_en,
        input  hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Produces horizontal and
//   vertical pixel counters together with sync/blanking flags and a
//   frame-start pulse. Every output is a flop, and the flags are derived
//   from the *next* counter values so they are registered on the same edge
//   as the counters: the whole output tuple always describes one pixel.
//
//   Ports:
//     clk  system/pixel clock
//     rst  asynchronous, active-high reset; forces (0,0) with all flags low
//     vga  vga_timing_gen_if.master
//            pix_en in : advance one pixel on this clk edge
//            hcount/vcount, hsync/hblnk, vsync/vblnk, frame_start out
module vga_timing_gen #(
    parameter int H_PIXELS     = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_TIME  = 128,
    parameter int H_TOTAL      = 1056,
    parameter int V_PIXELS     = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_TIME  = 4,
    parameter int V_TOTAL      = 628,
    parameter int CNT_W        = 11
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_gen_if.master vga
);

    // Thresholds are held one bit wider than the counters so that a sync
    // end equal to 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0] H_LAST     = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT      = (CNT_W+1)'(H_PIXELS);
    localparam logic [CNT_W:0] H_SYNC_BEG = (CNT_W+1)'(H_SYNC_START);
    localparam logic [CNT_W:0] H_SYNC_END = (CNT_W+1)'(H_SYNC_START + H_SYNC_TIME);
    localparam logic [CNT_W:0] V_LAST     = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] V_ACT      = (CNT_W+1)'(V_PIXELS);
    localparam logic [CNT_W:0] V_SYNC_BEG = (CNT_W+1)'(V_SYNC_START);
    localparam logic [CNT_W:0] V_SYNC_END = (CNT_W+1)'(V_SYNC_START + V_SYNC_TIME);

    // Parameter legality, rejected at elaboration.
    generate
        if (!(H_PIXELS < H_SYNC_START)) begin : g_bad_h_sync_start
            $error("vga_timing_gen: H_PIXELS must be below H_SYNC_START");
        end
        if (!(H_SYNC_START + H_SYNC_TIME <= H_TOTAL)) begin : g_bad_h_sync_end
            $error("vga_timing_gen: horizontal sync must end within H_TOTAL");
        end
        if (!(V_PIXELS < V_SYNC_START)) begin : g_bad_v_sync_start
            $error("vga_timing_gen: V_PIXELS must be below V_SYNC_START");
        end
        if (!(V_SYNC_START + V_SYNC_TIME <= V_TOTAL)) begin : g_bad_v_sync_end
            $error("vga_timing_gen: vertical sync must end within V_TOTAL");
        end
        if (!((64'd1 << CNT_W) >= 64'(H_TOTAL) && (64'd1 << CNT_W) >= 64'(V_TOTAL))) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic [CNT_W-1:0] hcount_reg, hcount_next;
    logic [CNT_W-1:0] vcount_reg, vcount_next;
    logic             hsync_reg, hsync_next;
    logic             hblnk_reg, hblnk_next;
    logic             vsync_reg, vsync_next;
    logic             vblnk_reg, vblnk_next;
    logic             frame_start_reg, frame_start_next;
    logic             h_wrap, v_wrap;

    always_comb begin
        h_wrap = ({1'b0, hcount_reg} == H_LAST);
        v_wrap = ({1'b0, vcount_reg} == V_LAST);

        hcount_next = h_wrap ? '0 : hcount_reg + 1'b1;
        vcount_next = vcount_reg;
        if (h_wrap) begin
            vcount_next = v_wrap ? '0 : vcount_reg + 1'b1;
        end

        // Flags come from the next counter values so they land together
        // with the counters on the same edge.
        hblnk_next = ({1'b0, hcount_next} >= H_ACT);
        hsync_next = ({1'b0, hcount_next} >= H_SYNC_BEG) &&
                     ({1'b0, hcount_next} <  H_SYNC_END);
        vblnk_next = ({1'b0, vcount_next} >= V_ACT);
        vsync_next = ({1'b0, vcount_next} >= V_SYNC_BEG) &&
                     ({1'b0, vcount_next} <  V_SYNC_END);

        // Only a genuine frame wrap reaches (0,0) this way; reset lands there
        // through the reset branch and so never raises the pulse.
        frame_start_next = h_wrap && v_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            hsync_reg       <= 1'b0;
            hblnk_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            vblnk_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (vga.pix_en) begin
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            hsync_reg       <= hsync_next;
            hblnk_reg       <= hblnk_next;
            vsync_reg       <= vsync_next;
            vblnk_reg       <= vblnk_next;
            frame_start_reg <= frame_start_next;
        end else begin
            // Stalled pixel: everything holds, but the pulse must not be
            // stretched across the stall.
            frame_start_reg <= 1'b0;
        end
    end

    assign vga.hcount      = hcount_reg;
    assign vga.vcount      = vcount_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.hblnk       = hblnk_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.vblnk       = vblnk_reg;
    assign vga.frame_start = frame_start_reg;

endmodule
